// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, default latencies, counter width.
// MADD/MSUB encodings only take effect when the build defines MD_MADD_EN.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MSUB  = 3'd7;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 6;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider, signed or unsigned; signed results truncate toward zero and the
// remainder follows the dividend's sign. A zero divisor raises div_zero and the results are don't-care.
module md_div_core
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    // Divide magnitudes, then restore signs; a zero divisor is replaced by one to keep the datapath defined.
    always_comb begin
        neg_a_s  = is_signed & dividend[31];
        neg_b_s  = is_signed & divisor[31];
        div_zero = (divisor == 32'd0);
        if (neg_a_s) begin
            mag_a_s = ~dividend + 32'd1;
        end else begin
            mag_a_s = dividend;
        end
        if (div_zero) begin
            mag_b_s = 32'd1;
        end else if (neg_b_s) begin
            mag_b_s = ~divisor + 32'd1;
        end else begin
            mag_b_s = divisor;
        end
        q_mag_s = mag_a_s / mag_b_s;
        r_mag_s = mag_a_s % mag_b_s;
        // 0x80000000 / -1 wraps back to 0x80000000 through the two's-complement negate.
        if (neg_a_s ^ neg_b_s) begin
            quotient = ~q_mag_s + 32'd1;
        end else begin
            quotient = q_mag_s;
        end
        if (neg_a_s) begin
            remainder = ~r_mag_s + 32'd1;
        end else begin
            remainder = r_mag_s;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; fixed latency per op class, busy drives the stall.
// Optional MADD/MSUB accumulate ops are enabled by defining MD_MADD_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        md_hazard
);

    md_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic [31:0]      op_a_r, op_a_s;
    logic [31:0]      op_b_r, op_b_s;
    logic [2:0]       op_r, op_s;

    logic [63:0]      prod_signed_s;
    logic [63:0]      prod_unsigned_s;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic             div_zero_s;

    assign prod_signed_s   = $signed({{32{op_a_r[31]}}, op_a_r}) * $signed({{32{op_b_r[31]}}, op_b_r});
    assign prod_unsigned_s = {32'd0, op_a_r} * {32'd0, op_b_r};

    md_div_core u_div
    (
        .dividend  (op_a_r),
        .divisor   (op_b_r),
        .is_signed (op_r == MD_DIV),
        .quotient  (quot_s),
        .remainder (rem_s),
        .div_zero  (div_zero_s)
    );

    // Next-state logic: launch from idle, count down while busy, write HI/LO when the counter reaches one.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        op_a_s  = op_a_r;
        op_b_s  = op_b_r;
        op_s    = op_r;
        case (state_r)
            MD_IDLE: begin
                if (start) begin
                    case (md_op)
`ifdef MD_MADD_EN
                        MD_MULT, MD_MULTU, MD_MADD, MD_MSUB: begin
`else
                        MD_MULT, MD_MULTU: begin
`endif
                            state_s = MD_BUSY;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            op_a_s  = rs_data;
                            op_b_s  = rt_data;
                            op_s    = md_op;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_s = MD_BUSY;
                            cnt_s   = CNT_W'(DIV_CYCLES);
                            op_a_s  = rs_data;
                            op_b_s  = rt_data;
                            op_s    = md_op;
                        end
                        MD_MTHI: hi_s = rs_data;
                        MD_MTLO: lo_s = rs_data;
                        default: begin
                            state_s = MD_IDLE;
                        end
                    endcase
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                // start is ignored here: the operation in flight always runs to completion.
                if (cnt_r == CNT_W'(1)) begin
                    state_s = MD_IDLE;
                    cnt_s   = '0;
                    case (op_r)
                        MD_MULT:  {hi_s, lo_s} = prod_signed_s;
                        MD_MULTU: {hi_s, lo_s} = prod_unsigned_s;
                        MD_DIV, MD_DIVU: begin
                            if (!div_zero_s) begin
                                hi_s = rem_s;
                                lo_s = quot_s;
                            end else begin
                                hi_s = hi_r;
                                lo_s = lo_r;
                            end
                        end
`ifdef MD_MADD_EN
                        MD_MADD:  {hi_s, lo_s} = {hi_r, lo_r} + prod_signed_s;
                        MD_MSUB:  {hi_s, lo_s} = {hi_r, lo_r} - prod_signed_s;
`endif
                        default: begin
                            hi_s = hi_r;
                            lo_s = lo_r;
                        end
                    endcase
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = MD_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, counter, latched operands and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            op_a_r  <= 32'd0;
            op_b_r  <= 32'd0;
            op_r    <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            op_a_r  <= op_a_s;
            op_b_r  <= op_b_s;
            op_r    <= op_s;
        end
    end

    assign busy      = (state_r == MD_BUSY);
    assign md_hazard = start | busy;
    assign md_out    = rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results and busy-cycle counts.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_sel;
    logic [31:0] md_out;
    logic        busy;
    logic        md_hazard;

    int n_checks;
    int n_fails;

    md_unit dut
    (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .rd_sel    (rd_sel),
        .md_out    (md_out),
        .busy      (busy),
        .md_hazard (md_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        rd_sel = 1'b1;
        #1;
        check_eq({tag, "_hi"}, md_out, exp_hi);
        rd_sel = 1'b0;
        #1;
        check_eq({tag, "_lo"}, md_out, exp_lo);
    endtask

    // Launch a multi-cycle op, scramble operands after the start edge, optionally pulse an ignored
    // MTLO start in busy cycle pulse_at, and count busy cycles.
    task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_cyc, input int pulse_at);
        int n;
        @(negedge clk);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        check_eq({tag, "_hazard0"}, {31'd0, md_hazard}, 32'd1);
        @(negedge clk);
        start   = 1'b0;
        md_op   = MD_MULT;
        rs_data = 32'h5A5A_5A5A;
        rt_data = 32'hA5A5_0003;
        n = 0;
        while (busy && n < 64) begin
            n++;
            if (n == pulse_at) begin
                start   = 1'b1;
                md_op   = MD_MTLO;
                rs_data = 32'h0000_0BAD;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, "_busy_cycles"}, n, exp_cyc);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        rd_sel   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hazard", {31'd0, md_hazard}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);

        run_long("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_long("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 0);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        run_long("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_long("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
        check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        run_long("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd2, 10, 0);
        check_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFF);

        // Preload HI/LO, then divide by zero with an ignored start in the middle.
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; rs_data = 32'h11;
        @(negedge clk);
        md_op = MD_MTLO; rs_data = 32'h22;
        @(negedge clk);
        start = 1'b0;
        run_long("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 3);
        check_hilo("divu_zero", 32'h0000_0011, 32'h0000_0022);

        // Back-to-back MTHI/MTLO: no busy, HI visible one cycle later.
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        md_op = MD_MTLO; rs_data = 32'h1234_5678;
        rd_sel = 1'b1;
        #1;
        check_eq("mthi_busy", {31'd0, busy}, 32'd0);
        check_eq("mthi_out", md_out, 32'hDEAD_BEEF);
        @(negedge clk);
        start = 1'b0;
        check_eq("mtlo_busy", {31'd0, busy}, 32'd0);
        check_hilo("mtlo", 32'hDEAD_BEEF, 32'h1234_5678);

`ifdef MD_MADD_EN
        run_long("madd", MD_MADD, 32'd2, 32'd3, 5, 0);
        check_hilo("madd", 32'hDEAD_BEEF, 32'h1234_567E);
        run_long("msub", MD_MSUB, 32'd1, 32'h1234_5680, 5, 0);
        check_hilo("msub", 32'hDEAD_BEEE, 32'hFFFF_FFFE);
`else
        @(negedge clk);
        start = 1'b1; md_op = MD_MADD; rs_data = 32'd5; rt_data = 32'd7;
        @(negedge clk);
        md_op = MD_MSUB;
        check_eq("rsv6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("rsv7_busy", {31'd0, busy}, 32'd0);
        check_hilo("rsv", 32'hDEAD_BEEF, 32'h1234_5678);
`endif

        // Reset during busy cycle 4 discards the divide.
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("prerst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_hilo("midrst", 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        check_eq("midrst_late_busy", {31'd0, busy}, 32'd0);
        check_hilo("midrst_late", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit inside the EX stage, directly upstream of the MEM stage.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, plus mthi/mtlo writes.
- Holds the HI/LO architectural registers.
- Drives mfhi/mflo read data onto the EX result path, which becomes aluout_mem. Exposes busy so the hazard unit can stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch the operation given by md_op this cycle
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (MADD/MSUB, see feature)
- rs_data  in  32  operand A (forwarded rs)
- rt_data  in  32  operand B (forwarded rt)
- rd_sel  in  1  read select: 1 selects HI, 0 selects LO
- md_out  out  32  combinational rd_sel ? HI : LO
- busy  out  1  operation in flight
- md_hazard  out  1  start | busy; the hazard unit stalls any md instruction in D on this

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, latched operands=0. Any in-flight operation is discarded with no HI/LO update.
- Idle + start + MULT/MULTU/DIV/DIVU:
  - Latch rs_data, rt_data and op at edge E0.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from E0 until edge E_N, where N is the latency; busy is high for exactly N cycles.
  - At E_N: HI/LO are written and busy falls on the same edge. md_out shows the new value in the cycle after E_N.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: HI and LO are left unchanged, but busy still runs the full DIV_CYCLES.
- Idle + start + MTHI/MTLO: HI (or LO) = rs_data at the next edge, with no busy cycles.
- start while busy: ignored. The hazard unit guarantees this never happens; the bench checks it as an assertion.
- Reserved md_op with start and the feature out: no effect.
- Operands are sampled only at the start edge. Later changes to rs_data/rt_data do not affect the result.
- Counter decrements once per cycle; the writeback condition is counter==1.

Optional Feature:
- Macro: MD_MADD_EN
- Defined:
  - md_op 6 = MADD: {HI,LO} += signed rs*rt.
  - md_op 7 = MSUB: {HI,LO} -= signed rs*rt.
  - Both use MULT_CYCLES latency. The accumulate uses HI/LO values as they stand at E_N.
  - 64-bit arithmetic wraps.
- Undefined: ops 6/7 are ignored; busy stays 0 and HI/LO are unchanged.

Decomposition:
- Package md_pkg holds:
  - md_op encodings (MD_MULT … MD_MSUB)
  - default latencies
  - 6-bit counter width constant
- One natural sub-module: md_div_core, the combinational signed/unsigned 32-bit divide producing quotient and remainder plus a divide-by-zero flag.
- Multiply is inline.

Test Plan:
- MULT: rs=0xFFFFFFFE (-2), rt=3, start at cycle 0.
  - Expect busy=1 for cycles 1-5 and md_hazard=1 in cycle 0.
  - Expect HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 6.
- MULTU: same operands. Expect HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV: rs=-7, rt=2. Expect LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 10 busy cycles.
- DIVU: rs=7, rt=0, with HI=0x11, LO=0x22 beforehand. Expect busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- MTHI 0xDEADBEEF then MTLO 0x12345678 in back-to-back cycles. Expect no busy, and md_out(rd_sel=1)=0xDEADBEEF one cycle later.
- Reset mid-operation: start DIV, assert reset in busy cycle 4.
  - Expect HI=LO=0 and busy=0 the next cycle.
  - Expect no later writeback.
  - Changing rs_data during a mult has no effect on the result.
